// File: rtl/seg_scan_mux.sv
// -----------------------------------------------------------------------------
// seg_scan_mux
//
// Time-multiplexed driver for an N-digit 7-segment display. One digit is lit
// at a time. Each digit owns a slot of REFRESH_DIV clock cycles. The first
// BLANK_CYCLES cycles of a slot are dark, which stops ghosting while the
// anode and segment lines settle. The digit pattern and its blank bit are
// captured once, at the end of the dark phase, and held for the rest of the
// slot.
//
// Parameters
//   NUM_DIGITS       number of digits scanned (>= 2)
//   SEG_WIDTH        segment bits per digit
//   REFRESH_DIV      clk cycles per digit slot (>= BLANK_CYCLES + 1)
//   BLANK_CYCLES     dark cycles at the start of every slot (>= 1)
//   ANODE_ACTIVE_LOW 1: the selected anode is driven 0; 0: it is driven 1
//   SEG_ACTIVE_LOW   1: a lit segment is driven 0; 0: it is driven 1
//
// Ports
//   clk          system clock
//   rst_n        asynchronous active-low reset
//   enable       scan enable; low forces the display dark and restarts the
//                scan from digit 0
//   digits       packed patterns, digit k at [k*SEG_WIDTH +: SEG_WIDTH],
//                1 = segment lit (logical polarity)
//   blank_mask   bit k = 1 keeps digit k dark
//   seg          registered segment drive (physical polarity)
//   anode        registered one-hot anode drive (physical polarity)
//   digit_idx    index of the digit that owns the current slot
//   frame_start  one-cycle pulse in the first cycle of a digit-0 slot that
//                follows a wrap from the last digit
// -----------------------------------------------------------------------------
module seg_scan_mux #(
    parameter int NUM_DIGITS       = 4,
    parameter int SEG_WIDTH        = 7,
    parameter int REFRESH_DIV      = 1024,
    parameter int BLANK_CYCLES     = 16,
    parameter int ANODE_ACTIVE_LOW = 1,
    parameter int SEG_ACTIVE_LOW   = 0,
    localparam int IDX_W           = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            enable,
    input  logic [NUM_DIGITS*SEG_WIDTH-1:0] digits,
    input  logic [NUM_DIGITS-1:0]           blank_mask,
    output logic [SEG_WIDTH-1:0]            seg,
    output logic [NUM_DIGITS-1:0]           anode,
    output logic [IDX_W-1:0]                digit_idx,
    output logic                            frame_start
);

    // -------------------------------------------------------------------------
    // Constants
    // -------------------------------------------------------------------------
    localparam int CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;

    localparam logic [CNT_W-1:0] CNT_ZERO      = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE       = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_LAST      = CNT_W'(REFRESH_DIV - 1);
    localparam logic [CNT_W-1:0] CNT_BLANK_END = CNT_W'(BLANK_CYCLES - 1);

    localparam logic [IDX_W-1:0] IDX_ZERO = {IDX_W{1'b0}};
    localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);

    // Physical levels that leave every digit and every segment dark.
    localparam logic [NUM_DIGITS-1:0] ANODE_OFF =
        (ANODE_ACTIVE_LOW != 0) ? {NUM_DIGITS{1'b1}} : {NUM_DIGITS{1'b0}};
    localparam logic [SEG_WIDTH-1:0]  SEG_OFF   =
        (SEG_ACTIVE_LOW != 0)   ? {SEG_WIDTH{1'b1}}  : {SEG_WIDTH{1'b0}};

    typedef enum logic [0:0] {
        ST_BLANK = 1'b0,
        ST_ON    = 1'b1
    } state_t;

    // -------------------------------------------------------------------------
    // Helpers
    // -------------------------------------------------------------------------

    // Map a logical pattern (1 = lit) to the physical segment level.
    function automatic logic [SEG_WIDTH-1:0] seg_drive(
        input logic [SEG_WIDTH-1:0] lit_pattern
    );
        logic [SEG_WIDTH-1:0] drv;
        drv = (SEG_ACTIVE_LOW != 0) ? ~lit_pattern : lit_pattern;
        return drv;
    endfunction

    // Physical anode vector that selects only digit idx.
    function automatic logic [NUM_DIGITS-1:0] anode_drive(
        input logic [IDX_W-1:0] idx
    );
        logic [NUM_DIGITS-1:0] onehot;
        onehot = {NUM_DIGITS{1'b0}};
        for (int k = 0; k < NUM_DIGITS; k++) begin
            onehot[k] = (idx == IDX_W'(k));
        end
        return (ANODE_ACTIVE_LOW != 0) ? ~onehot : onehot;
    endfunction

    // Index of the digit that follows idx in scan order.
    function automatic logic [IDX_W-1:0] next_idx(
        input logic [IDX_W-1:0] idx
    );
        logic [IDX_W-1:0] nxt;
        nxt = (idx == IDX_LAST) ? IDX_ZERO : (idx + IDX_ONE);
        return nxt;
    endfunction

    // -------------------------------------------------------------------------
    // State
    // -------------------------------------------------------------------------
    state_t                  state_q,       state_d;
    logic [CNT_W-1:0]        cnt_q,         cnt_d;
    logic [IDX_W-1:0]        digit_idx_q,   digit_idx_d;
    logic [SEG_WIDTH-1:0]    seg_q,         seg_d;
    logic [NUM_DIGITS-1:0]   anode_q,       anode_d;
    logic                    frame_start_q, frame_start_d;

    // Pattern and blank bit of the digit that owns the current slot.
    logic [SEG_WIDTH-1:0]    sel_pat_s;
    logic                    sel_blank_s;

    // Select the pattern and blank bit of the current digit. This is an
    // AND-OR mux, so an index past the last digit selects nothing.
    always_comb begin
        sel_pat_s   = {SEG_WIDTH{1'b0}};
        sel_blank_s = 1'b0;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            sel_pat_s   = sel_pat_s |
                          ((digit_idx_q == IDX_W'(k)) ?
                           digits[k*SEG_WIDTH +: SEG_WIDTH] : {SEG_WIDTH{1'b0}});
            sel_blank_s = sel_blank_s |
                          ((digit_idx_q == IDX_W'(k)) & blank_mask[k]);
        end
    end

    // Next-state logic for the slot counter, the scan FSM and the output
    // registers.
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q + CNT_ONE;
        digit_idx_d   = digit_idx_q;
        seg_d         = seg_q;
        anode_d       = anode_q;
        frame_start_d = 1'b0;

        if (!enable) begin
            // Disable takes priority over a slot end that falls on the same
            // edge. The next scan starts from a clean digit-0 dark phase.
            state_d     = ST_BLANK;
            cnt_d       = CNT_ZERO;
            digit_idx_d = IDX_ZERO;
            seg_d       = SEG_OFF;
            anode_d     = ANODE_OFF;
        end else begin
            case (state_q)
                ST_BLANK: begin
                    if (cnt_q == CNT_BLANK_END) begin
                        // Capture the pattern for the lit phase. Later changes
                        // on digits or blank_mask wait for the next slot.
                        state_d = ST_ON;
                        if (sel_blank_s) begin
                            seg_d   = SEG_OFF;
                            anode_d = ANODE_OFF;
                        end else begin
                            seg_d   = seg_drive(sel_pat_s);
                            anode_d = anode_drive(digit_idx_q);
                        end
                    end else begin
                        seg_d   = SEG_OFF;
                        anode_d = ANODE_OFF;
                    end
                end

                ST_ON: begin
                    if (cnt_q == CNT_LAST) begin
                        // End of slot: go dark and move to the next digit.
                        // A wrap to digit 0 marks the start of a new frame.
                        state_d       = ST_BLANK;
                        cnt_d         = CNT_ZERO;
                        digit_idx_d   = next_idx(digit_idx_q);
                        seg_d         = SEG_OFF;
                        anode_d       = ANODE_OFF;
                        frame_start_d = (digit_idx_q == IDX_LAST);
                    end else begin
                        seg_d   = seg_q;
                        anode_d = anode_q;
                    end
                end

                default: begin
                    state_d     = ST_BLANK;
                    cnt_d       = CNT_ZERO;
                    digit_idx_d = IDX_ZERO;
                    seg_d       = SEG_OFF;
                    anode_d     = ANODE_OFF;
                end
            endcase
        end
    end

    // Scan state and output registers. Reset darkens the display at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_BLANK;
            cnt_q         <= CNT_ZERO;
            digit_idx_q   <= IDX_ZERO;
            seg_q         <= SEG_OFF;
            anode_q       <= ANODE_OFF;
            frame_start_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            digit_idx_q   <= digit_idx_d;
            seg_q         <= seg_d;
            anode_q       <= anode_d;
            frame_start_q <= frame_start_d;
        end
    end

    // -------------------------------------------------------------------------
    // Outputs: taken straight from registers.
    // -------------------------------------------------------------------------
    assign seg         = seg_q;
    assign anode       = anode_q;
    assign digit_idx   = digit_idx_q;
    assign frame_start = frame_start_q;

endmodule

// File: tb/tb_seg_scan_mux.sv
// -----------------------------------------------------------------------------
// tb_seg_scan_mux
//
// Directed bench for seg_scan_mux with NUM_DIGITS=4, SEG_WIDTH=7,
// REFRESH_DIV=8 and BLANK_CYCLES=2. It runs two instances in parallel on the
// same stimulus:
//   u_a  active-low anodes, active-high segments
//   u_b  active-high anodes, active-low segments
// The bench samples outputs on the falling clock edge. Sample k is the k-th
// falling edge after reset release or re-enable. In sample k:
//   - the slot counter is k % 8
//   - the digit is (k / 8) % 4
//   - the display is lit when the counter is 2 or more
//   - frame_start is high when k is a non-zero multiple of 32
// -----------------------------------------------------------------------------
module tb_seg_scan_mux;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        enable;
    logic [27:0] digits;
    logic [3:0]  blank_mask;

    logic [6:0]  seg_a,   seg_b;
    logic [3:0]  anode_a, anode_b;
    logic [1:0]  idx_a,   idx_b;
    logic        fs_a,    fs_b;

    int n_asrt = 0;
    int n_fail = 0;
    int cur_k  = -1;

    logic [6:0] pat_tbl [4];

    always #5 clk = ~clk;

    seg_scan_mux #(
        .NUM_DIGITS(4), .SEG_WIDTH(7), .REFRESH_DIV(8), .BLANK_CYCLES(2),
        .ANODE_ACTIVE_LOW(1), .SEG_ACTIVE_LOW(0)
    ) u_a (
        .clk(clk), .rst_n(rst_n), .enable(enable), .digits(digits),
        .blank_mask(blank_mask), .seg(seg_a), .anode(anode_a),
        .digit_idx(idx_a), .frame_start(fs_a)
    );

    seg_scan_mux #(
        .NUM_DIGITS(4), .SEG_WIDTH(7), .REFRESH_DIV(8), .BLANK_CYCLES(2),
        .ANODE_ACTIVE_LOW(0), .SEG_ACTIVE_LOW(1)
    ) u_b (
        .clk(clk), .rst_n(rst_n), .enable(enable), .digits(digits),
        .blank_mask(blank_mask), .seg(seg_b), .anode(anode_b),
        .digit_idx(idx_b), .frame_start(fs_b)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_asrt++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s k=%0d observed=%0h expected=%0h", tag, cur_k, obs, exp);
        end
    endtask

    // Fully dark, digit index 0 and no frame pulse on both instances.
    task automatic dark_check(input int kk);
        cur_k = kk;
        chk("dark_anode_a", {28'd0, anode_a}, 32'h0000_000F);
        chk("dark_seg_a",   {25'd0, seg_a},   32'h0000_0000);
        chk("dark_idx_a",   {30'd0, idx_a},   32'h0000_0000);
        chk("dark_fs_a",    {31'd0, fs_a},    32'h0000_0000);
        chk("dark_anode_b", {28'd0, anode_b}, 32'h0000_0000);
        chk("dark_seg_b",   {25'd0, seg_b},   32'h0000_007F);
        chk("dark_idx_b",   {30'd0, idx_b},   32'h0000_0000);
        chk("dark_fs_b",    {31'd0, fs_b},    32'h0000_0000);
    endtask

    // Check sample kk of a running scan. blanked marks a digit slot that the
    // mask keeps dark. d0 is the pattern expected on digit 0.
    task automatic sample_check(input int kk, input bit blanked, input logic [6:0] d0);
        int         cnt;
        int         idx;
        bit         lit;
        logic [6:0] pe;
        logic [3:0] oh;
        logic [3:0] an_e;
        logic [3:0] an_b_e;
        logic [6:0] sg_e;
        logic [6:0] sg_b_e;
        logic       fs_e;
        cur_k  = kk;
        cnt    = kk % 8;
        idx    = (kk / 8) % 4;
        lit    = (cnt >= 2) && !blanked;
        pe     = (idx == 0) ? d0 : pat_tbl[idx];
        oh     = 4'b0001 << idx;
        an_e   = lit ? ~oh : 4'b1111;
        sg_e   = lit ? pe : 7'h00;
        an_b_e = ~an_e;
        sg_b_e = ~sg_e;
        fs_e   = (kk > 0) && ((kk % 32) == 0);
        chk("anode_a", {28'd0, anode_a}, {28'd0, an_e});
        chk("seg_a",   {25'd0, seg_a},   {25'd0, sg_e});
        chk("idx_a",   {30'd0, idx_a},   idx);
        chk("fs_a",    {31'd0, fs_a},    {31'd0, fs_e});
        chk("anode_b", {28'd0, anode_b}, {28'd0, an_b_e});
        chk("seg_b",   {25'd0, seg_b},   {25'd0, sg_b_e});
        chk("idx_b",   {30'd0, idx_b},   idx);
        chk("fs_b",    {31'd0, fs_b},    {31'd0, fs_e});
    endtask

    initial begin
        pat_tbl[0] = 7'h3F;
        pat_tbl[1] = 7'h4F;
        pat_tbl[2] = 7'h5B;
        pat_tbl[3] = 7'h06;

        rst_n      = 1'b0;
        enable     = 1'b1;
        digits     = {7'h06, 7'h5B, 7'h4F, 7'h3F};
        blank_mask = 4'b0000;

        // Values held during reset, with the clock running.
        repeat (3) @(negedge clk);
        dark_check(-1);

        // Release the reset. Sample 0 is this falling edge.
        @(negedge clk);
        rst_n = 1'b1;
        sample_check(0, 1'b0, 7'h3F);

        // Three full frames and part of a fourth. Along the way:
        //   - change digit 0 while it is lit (snapshot)
        //   - blank digit 2 for one frame
        for (int k = 1; k <= 114; k++) begin
            @(negedge clk);
            sample_check(k, (k >= 80) && (k <= 87), (k < 64) ? 7'h3F : 7'h06);
            if (k == 34) begin
                digits[6:0] = 7'h06;
            end
            if (k == 72) begin
                blank_mask = 4'b0100;
            end
            if (k == 100) begin
                blank_mask = 4'b0000;
            end
        end

        // Sample 114 has digit 2 lit. Drop enable for three cycles.
        enable = 1'b0;
        for (int j = 115; j <= 117; j++) begin
            @(negedge clk);
            dark_check(j);
        end
        enable = 1'b1;

        // The scan restarts at a digit-0 dark phase, with no frame pulse until
        // the first wrap.
        for (int j = 1; j <= 42; j++) begin
            @(negedge clk);
            sample_check(j, 1'b0, 7'h06);
        end

        // Sample 42 has digit 1 lit. Assert reset between clock edges; the
        // outputs must go dark with no clock edge.
        #2;
        rst_n = 1'b0;
        #1;
        dark_check(-2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
        $finish;
    end

endmodule

// File: doc/seg_scan_mux.md
Name: seg_scan_mux

Overview:
- Parametrised time-multiplexed driver for an N-digit 7-segment display.
- Internal refresh divider, per-digit dead time for anti-ghosting, per-digit blanking, pattern snapshot per slot, and a frame-start strobe.
- Sits between the digit-pattern encoders and the FPGA segment/anode pins.
- Replaces externally divided 2-digit multiplexing.

Parameters:
- NUM_DIGITS, 4, number of digits scanned (>=2).
- SEG_WIDTH, 7, segment bits per digit.
- REFRESH_DIV, 1024, clk cycles per digit slot (>= BLANK_CYCLES+1).
- BLANK_CYCLES, 16, dead-time cycles at start of each slot (>=1).
- ANODE_ACTIVE_LOW, 1, 1 = selected anode driven 0; 0 = driven 1.
- SEG_ACTIVE_LOW, 0, 1 = lit segment driven 0; 0 = lit segment driven 1.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- enable  in  1  scan enable; low forces display dark and rescan from digit 0.
- digits  in  NUM_DIGITS*SEG_WIDTH  patterns; digit k at bits [k*SEG_WIDTH +: SEG_WIDTH]; 1 = segment lit (logical).
- blank_mask  in  NUM_DIGITS  bit k=1 keeps digit k dark.
- seg  out  SEG_WIDTH  registered segment drive, polarity per SEG_ACTIVE_LOW.
- anode  out  NUM_DIGITS  registered one-hot anode drive, bit k = digit k, polarity per ANODE_ACTIVE_LOW.
- digit_idx  out  clog2(NUM_DIGITS)  index of current slot.
- frame_start  out  1  one-cycle pulse at start of a digit-0 slot after wrap.

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-low (rst_n).
- Reset values:
  - state=BLANK, slot counter=0, digit_idx=0, frame_start=0.
  - anode = all inactive (all 1s if ANODE_ACTIVE_LOW).
  - seg = all off (all 0s if SEG_ACTIVE_LOW=0).
- Slot counter:
  - Width clog2(REFRESH_DIV).
  - Increments every enabled cycle.
  - Wraps to 0 after REFRESH_DIV-1.
- State BLANK:
  - Anodes inactive, segs off.
  - Exit to ON on the edge where counter==BLANK_CYCLES-1.
  - On that edge: seg <= digits[digit_idx] (polarity-applied) and anode <= active bit digit_idx. If blank_mask[digit_idx]=1, both stay inactive/off.
  - This is the snapshot: digits/blank_mask changes during ON have no effect until the next slot.
- State ON:
  - Outputs held.
  - On the edge where counter==REFRESH_DIV-1:
    - state <= BLANK, counter <= 0, outputs <= inactive/off.
    - digit_idx <= digit_idx+1, or 0 when digit_idx==NUM_DIGITS-1.
- Latencies:
  - Each slot is exactly REFRESH_DIV cycles: BLANK_CYCLES dark, then REFRESH_DIV-BLANK_CYCLES lit.
  - Full frame = NUM_DIGITS*REFRESH_DIV cycles.
- frame_start:
  - Registered.
  - High for exactly the first cycle of the slot where digit_idx wrapped NUM_DIGITS-1 -> 0.
  - Not asserted after reset or after enable rises.
- enable low (synchronous, sampled each edge): next state BLANK, counter 0, digit_idx 0, outputs inactive, frame_start 0.
- enable high again: scan restarts at a digit-0 BLANK phase.
- Simultaneous enable low and slot end: enable wins.
- Mid-operation rst_n low: outputs go dark immediately (async), regardless of clk.
- At most one anode bit is ever active, and never during BLANK, so no two digits overlap.
- Outputs are purely registered; no combinational path from digits/blank_mask to seg/anode.

Test Plan:
All scenarios use NUM_DIGITS=4, SEG_WIDTH=7, REFRESH_DIV=8, BLANK_CYCLES=2, ANODE_ACTIVE_LOW=1, SEG_ACTIVE_LOW=0, unless noted.
- Reset hold, then release with enable=1 and digits={7'h06,7'h5B,7'h4F,7'h3F}:
  - During reset: anode=4'b1111, seg=0, digit_idx=0, frame_start=0.
  - After release: 2 dark cycles, then anode=4'b1110, seg=7'h3F for 6 cycles.
  - Then 2 dark cycles, then anode=4'b1101, seg=7'h4F.
- Full frame:
  - Digit order 0,1,2,3,0 with slot length 8.
  - frame_start high exactly one cycle at cycle 32 after the first slot start; next pulse 32 cycles later.
  - Never high during the first frame start after reset.
- Snapshot:
  - Change digits[6:0] from 7'h3F to 7'h06 mid-ON of digit 0 -> seg stays 7'h3F until the slot ends.
  - 7'h06 appears on the next digit-0 slot.
- blank_mask=4'b0100 -> digit 2 slot keeps anode=4'b1111, seg=0 for all 8 cycles; other digits unaffected; timing unchanged.
- enable deasserted mid-ON of digit 2, held 3 cycles, reasserted:
  - Next edge: anode=4'b1111, digit_idx=0.
  - After re-enable: 2 dark cycles then digit 0 lit; no frame_start pulse.
- Polarity: rerun scenario 1 with ANODE_ACTIVE_LOW=0, SEG_ACTIVE_LOW=1:
  - Dark state is anode=4'b0000, seg=7'h7F.
  - Digit 0 shows anode=4'b0001, seg=~7'h3F=7'h40.
